// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg
// Shared types and helpers for the 1-D convolution scheduler.
//   state_t   : scheduler phase encoding (LOAD, CLEAR, ISSUE, DRAIN, OUTPUT)
//   win_count : number of output windows for a given vector/filter length
package conv_sched_pkg;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    ISSUE,
    DRAIN,
    OUTPUT
  } state_t;

  // One output per valid filter placement: SIZE_X - SIZE_F + 1.
  function automatic int win_count(input int size_x, input int size_f);
    return size_x - size_f + 1;
  endfunction

endpackage

// File: rtl/conv_sched_addr_gen.sv
// conv_sched_addr_gen
// Window (k) and tap (j) counters of the convolution scheduler; produces the
// x-memory and filter-ROM read addresses while taps are being issued.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   issue              : high for each tap issue cycle (steps j)
//   win_next           : output handshake; advances k unless on last window
//   win_restart        : output handshake of the last window; k back to 0
//   issue_x_addr       : k + j during issue, else 0
//   f_addr             : j during issue, else 0
//   last_tap, last_win : j / k are at their final index
module conv_sched_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int SIZE_X = 128,
  parameter int SIZE_F = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue,
  input  logic                        win_next,
  input  logic                        win_restart,
  output logic [$clog2(SIZE_X)-1:0]   issue_x_addr,
  output logic [$clog2(SIZE_F)-1:0]   f_addr,
  output logic                        last_tap,
  output logic                        last_win
);

  localparam int NWIN = win_count(SIZE_X, SIZE_F);
  localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int FW   = $clog2(SIZE_F);
  localparam int XW   = $clog2(SIZE_X);

  logic [KW-1:0] win_k;
  logic [FW-1:0] tap_j;

  assign last_tap = (tap_j == FW'(SIZE_F - 1));
  assign last_win = (win_k == KW'(NWIN - 1));

  // Tap counter returns to 0 after the last tap so the next window starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_j <= '0;
    end else if (issue) begin
      tap_j <= last_tap ? '0 : tap_j + FW'(1);
    end
  end

  // Window counter saturates at the last window; only a restart clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_k <= '0;
    end else if (win_restart) begin
      win_k <= '0;
    end else if (win_next && !last_win) begin
      win_k <= win_k + KW'(1);
    end
  end

  assign issue_x_addr = issue ? (XW'(win_k) + XW'(tap_j)) : '0;
  assign f_addr       = issue ? tap_j : '0;

endmodule

// File: rtl/conv_sched.sv
// conv_sched
// Scheduler for a 1-D valid convolution: loads SIZE_X words into an external
// x-memory, then for each window k clears the MAC, issues SIZE_F taps, waits
// out the MAC latency and presents the accumulator on a valid/ready output.
// Optional feature macro: CONV_SCHED_RELU_EN (clamp negative results to 0).
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   x_valid / x_ready : input word handshake (LOAD phase only)
//   x_wr_en, x_addr   : x-memory write enable, shared write/read address
//   f_addr            : filter ROM address
//   mac_clear, mac_en : MAC accumulator clear / term enable
//   acc               : MAC accumulator value
//   y_data, y_valid,
//   y_ready           : result output handshake
//   busy              : high everywhere except an empty LOAD
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int SIZE_X  = 128,
  parameter int SIZE_F  = 8,
  parameter int T       = 16,
  parameter int MAC_LAT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic                      x_wr_en,
  output logic [$clog2(SIZE_X)-1:0] x_addr,
  output logic [$clog2(SIZE_F)-1:0] f_addr,
  output logic                      mac_clear,
  output logic                      mac_en,
  input  logic [T-1:0]              acc,
  output logic [T-1:0]              y_data,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic                      busy
);

  localparam int XW = $clog2(SIZE_X);
  localparam int DW = $clog2(MAC_LAT + 1) + 1;

  state_t          state, state_nx;
  logic [XW-1:0]   load_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            mac_en_r;
  logic [T-1:0]    y_data_r;
  logic [T-1:0]    capture_val;
  logic [XW-1:0]   issue_x_addr;
  logic            issue, last_tap, last_win;
  logic            load_last, handshake, drain_done;

  assign issue      = (state == ISSUE);
  assign x_ready    = (state == LOAD);
  assign x_wr_en    = x_valid & x_ready;
  assign load_last  = x_wr_en && (load_cnt == XW'(SIZE_X - 1));
  assign y_valid    = (state == OUTPUT);
  assign handshake  = y_valid & y_ready;
  assign mac_clear  = (state == CLEAR);
  assign mac_en     = mac_en_r;
  // DRAIN spans the last mac_en cycle plus MAC_LAT more, so acc is final
  // in the cycle where drain_cnt reaches MAC_LAT.
  assign drain_done = (drain_cnt == DW'(MAC_LAT));
  assign busy       = !((state == LOAD) && (load_cnt == '0));
  assign x_addr     = x_ready ? load_cnt : issue_x_addr;
  assign y_data     = y_data_r;

`ifdef CONV_SCHED_RELU_EN
  assign capture_val = acc[T-1] ? '0 : acc;
`else
  assign capture_val = acc;
`endif

  conv_sched_addr_gen #(
    .SIZE_X (SIZE_X),
    .SIZE_F (SIZE_F)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .issue        (issue),
    .win_next     (handshake),
    .win_restart  (handshake & last_win),
    .issue_x_addr (issue_x_addr),
    .f_addr       (f_addr),
    .last_tap     (last_tap),
    .last_win     (last_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (load_last)  state_nx = CLEAR;
      CLEAR:   state_nx = ISSUE;
      ISSUE:   if (last_tap)   state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = OUTPUT;
      OUTPUT:  if (handshake)  state_nx = last_win ? LOAD : CLEAR;
      default: state_nx = LOAD;
    endcase
  end

  // Load count wraps to 0 on the final accept, ready for the next vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt <= '0;
    end else if (x_wr_en) begin
      load_cnt <= load_last ? '0 : load_cnt + XW'(1);
    end
  end

  // mac_en trails each issue by one cycle to line up with memory read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_en_r  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      mac_en_r  <= issue;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_data_r <= '0;
    end else if ((state == DRAIN) && drain_done) begin
      y_data_r <= capture_val;
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched
// Scoreboard bench for conv_sched. A behavioural x-memory, filter ROM
// (f[j] = j+1, 1-cycle read) and 3-stage MAC surround the scheduler.
// Vector A: x[i] = i, so window k yields 36*k + 168.
// Vector B: x[0] = -5, all others 0, so window 0 yields -5 (0 under
// CONV_SCHED_RELU_EN) and the rest yield 0; reset aborts it in window 50.
module tb_conv_sched;

  localparam int SIZE_X  = 128;
  localparam int SIZE_F  = 8;
  localparam int T       = 16;
  localparam int MAC_LAT = 3;
  localparam int XW      = 7;
  localparam int FW      = 3;
  localparam int NWIN    = SIZE_X - SIZE_F + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          x_valid;
  logic          x_ready;
  logic          x_wr_en;
  logic [XW-1:0] x_addr;
  logic [FW-1:0] f_addr;
  logic          mac_clear;
  logic          mac_en;
  logic [T-1:0]  acc = '0;
  logic [T-1:0]  y_data;
  logic          y_valid;
  logic          y_ready;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  logic [T-1:0] sb_q[$];

  int phase   = 0;
  int acc_idx = 0;
  logic signed [T-1:0] x_mem [SIZE_X];
  logic signed [T-1:0] rd_x = '0;
  logic [T-1:0] rd_f = '0;
  logic [T-1:0] p0 = '0, p1 = '0;
  logic p0v = 1'b0, p1v = 1'b0;

  int  cyc = 0;
  int  out_cnt = 0;
  int  wr_cnt = 0;
  int  wr_err = 0;
  int  inv_err = 0;
  int  exp_win = 0;
  int  clr_cyc = -100;
  int  issue_err = 0;
  int  men_cnt = 0;
  int  men_err = 0;
  logic yv_prev = 1'b0;
  logic chk_xr = 1'b0;

  conv_sched #(
    .SIZE_X  (SIZE_X),
    .SIZE_F  (SIZE_F),
    .T       (T),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_wr_en   (x_wr_en),
    .x_addr    (x_addr),
    .f_addr    (f_addr),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .acc       (acc),
    .y_data    (y_data),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  function automatic logic [T-1:0] src_word(input int idx);
    if (phase == 0) return T'(idx);
    return (idx == 0) ? 16'hFFFB : 16'h0000;
  endfunction

  // Memory, ROM and MAC environment; acc reflects a mac_en term 3 cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_idx <= 0;
      rd_x <= '0; rd_f <= '0;
      p0 <= '0; p1 <= '0; p0v <= 1'b0; p1v <= 1'b0;
      acc <= '0;
    end else begin
      if (x_wr_en) begin
        x_mem[x_addr] <= src_word(acc_idx);
        acc_idx <= (acc_idx == SIZE_X - 1) ? 0 : acc_idx + 1;
      end
      rd_x <= x_mem[x_addr];
      rd_f <= T'(f_addr) + T'(1);
      p0v  <= mac_en;
      p0   <= T'(int'(rd_x) * int'(rd_f));
      p1v  <= p0v;
      p1   <= p0;
      if (mac_clear) acc <= '0;
      else if (p1v)  acc <= acc + p1;
    end
  end

  // Monitor: invariants, per-window timing and the output scoreboard.
  always @(negedge clk) begin
    int d;
    if (!reset) begin
      exp_win = 0;
      clr_cyc = -100;
      yv_prev = 1'b0;
      chk_xr  = 1'b0;
    end else begin
      if (mac_clear && mac_en) inv_err++;
      if (x_ready && (mac_en || mac_clear || y_valid)) inv_err++;
      if (y_valid && (mac_en || mac_clear)) inv_err++;
      if (x_wr_en !== (x_valid & x_ready)) inv_err++;
      if (chk_xr) begin
        check_output("x_ready low after last accept", 32'(x_ready), 32'd0);
        chk_xr = 1'b0;
      end
      if (x_wr_en) begin
        if (x_addr !== XW'(acc_idx)) wr_err++;
        wr_cnt++;
        if (acc_idx == SIZE_X - 1) chk_xr = 1'b1;
      end
      if (mac_clear) begin
        clr_cyc = cyc; issue_err = 0; men_cnt = 0; men_err = 0;
      end else begin
        d = cyc - clr_cyc;
        if (d >= 1 && d <= SIZE_F) begin
          if (x_addr !== XW'(exp_win + d - 1) || f_addr !== FW'(d - 1)) issue_err++;
        end
        if (mac_en) begin
          men_cnt++;
          if (d < 2 || d > SIZE_F + 1) men_err++;
        end
      end
      if (y_valid && !yv_prev) begin
        check_output("y_valid rise delay", 32'(cyc - clr_cyc), 32'd13);
        check_output("issue addr/mac_en pattern",
                     {16'(issue_err), 8'(men_err), 8'(men_cnt)}, 32'h0000_0008);
      end
      if (y_valid && y_ready) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected output", 32'(y_data), 32'hDEAD);
        end else begin
          check_output("y_data", 32'(y_data), 32'(sb_q.pop_front()));
        end
        out_cnt++;
        exp_win = (exp_win == NWIN - 1) ? 0 : exp_win + 1;
      end
      yv_prev = y_valid;
    end
    cyc++;
  end

  task automatic apply_stimulus();
    int wr_base;
    int stall_err;
    logic [T-1:0] held;

    // Reset values
    reset = 1'b1; x_valid = 1'b0; y_ready = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset flags {x_ready,wr,clr,en,yv,busy}",
                 32'({x_ready, x_wr_en, mac_clear, mac_en, y_valid, busy}), 32'b100000);
    check_output("reset x_addr", 32'(x_addr), 32'd0);
    check_output("reset f_addr", 32'(f_addr), 32'd0);
    check_output("reset y_data", 32'(y_data), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Vector A, first output stalled 20 cycles
    phase = 0;
    for (int k = 0; k < NWIN; k++) sb_q.push_back(T'(36 * k + 168));
    wr_base = wr_cnt;
    x_valid = 1'b1;
    repeat (130) @(posedge clk);
    #1 x_valid = 1'b0;
    check_output("A write count", 32'(wr_cnt - wr_base), 32'd128);
    for (int i = 0; i < 100 && y_valid !== 1'b1; i++) @(negedge clk);
    check_output("A first y_valid", 32'(y_valid), 32'd1);
    held = y_data;
    stall_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (y_valid !== 1'b1 || y_data !== held || mac_clear !== 1'b0) stall_err++;
    end
    check_output("stall stability", 32'(stall_err), 32'd0);
    @(posedge clk); #1 y_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("mac_clear after handshake", 32'(mac_clear), 32'd1);
    check_output("y_valid low after handshake", 32'(y_valid), 32'd0);
    for (int i = 0; i < 3000 && out_cnt < NWIN; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check_output("A output count", 32'(out_cnt), 32'(NWIN));
    check_output("x_ready after run", 32'(x_ready), 32'd1);
    check_output("busy after run", 32'(busy), 32'd0);

    // Vector B: negative window 0, then reset inside window 50 ISSUE
    phase = 1;
`ifdef CONV_SCHED_RELU_EN
    sb_q.push_back(16'h0000);
`else
    sb_q.push_back(16'hFFFB);
`endif
    for (int k = 1; k < 50; k++) sb_q.push_back(16'h0000);
    wr_base = wr_cnt;
    @(posedge clk); #1 x_valid = 1'b1;
    repeat (130) @(posedge clk);
    #1 x_valid = 1'b0;
    check_output("B write count", 32'(wr_cnt - wr_base), 32'd128);
    for (int i = 0; i < 2000 && out_cnt < NWIN + 50; i++) @(negedge clk);
    for (int i = 0; i < 20 && mac_clear !== 1'b1; i++) @(negedge clk);
    check_output("window 50 mac_clear", 32'(mac_clear), 32'd1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_output("abort flags {x_ready,wr,clr,en,yv,busy}",
                 32'({x_ready, x_wr_en, mac_clear, mac_en, y_valid, busy}), 32'b100000);
    check_output("abort x_addr", 32'(x_addr), 32'd0);
    check_output("abort f_addr", 32'(f_addr), 32'd0);
    check_output("abort y_data", 32'(y_data), 32'd0);
    check_output("scoreboard drained", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1 reset = 1'b1; x_valid = 1'b1;
    for (int i = 0; i < 10 && x_wr_en !== 1'b1; i++) @(negedge clk);
    check_output("restart first write", 32'({x_wr_en, x_addr}), 32'({1'b1, 7'd0}));
    @(posedge clk); #1 x_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("invariant violations", 32'(inv_err), 32'd0);
    check_output("write address errors", 32'(wr_err), 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
